// File: rtl/db_arbiter.sv
// Round-robin arbiter sharing one bus slave port between an instruction-fetch master (m0)
// and a data master (m1); a watchdog aborts transactions the slave never completes.
module db_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        m0_re,
    input  logic        m0_we,
    input  logic        m0_io,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    output logic [31:0] m0_dataIn,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_re,
    input  logic        m1_we,
    input  logic        m1_io,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    output logic [31:0] m1_dataIn,
    output logic        m1_done,
    output logic        m1_err,
    output logic        s_re,
    output logic        s_we,
    output logic        s_io,
    output logic [31:0] s_addr,
    output logic [31:0] s_dataOut,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,
    output logic [1:0]  dbg_state
);
    // Handshake: a master holds re|we and its address/data stable until it samples its
    // done pulse; the slave accepts a command on any cycle in which it shows s_ready=1.
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              rd_q, rd_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              s_re_q, s_re_d, s_we_q, s_we_d, s_io_q, s_io_d;
    logic [31:0]       s_addr_q, s_addr_d, s_dout_q, s_dout_d;
    logic [31:0]       m0_din_q, m0_din_d, m1_din_q, m1_din_d;
    logic              m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;

    logic pend0, pend1, pick, sel_re, sel_we;

    assign pend0  = m0_re | m0_we;
    assign pend1  = m1_re | m1_we;
    // On a tie the master that did not win last time is served.
    assign pick   = (pend0 && pend1) ? ~last_q : pend1;
    assign sel_re = pick ? m1_re : m0_re;
    assign sel_we = pick ? m1_we : m0_we;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        rd_d      = rd_q;
        wd_d      = wd_q;
        s_re_d    = 1'b0;
        s_we_d    = 1'b0;
        s_io_d    = s_io_q;
        s_addr_d  = s_addr_q;
        s_dout_d  = s_dout_q;
        m0_din_d  = m0_din_q;
        m1_din_d  = m1_din_q;
        m0_done_d = 1'b0;
        m1_done_d = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (s_ready && (pend0 || pend1)) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    wd_d     = '0;
                    s_re_d   = sel_re;
                    s_we_d   = sel_we;
                    s_io_d   = pick ? m1_io : m0_io;
                    s_addr_d = pick ? m1_addr : m0_addr;
                    s_dout_d = pick ? m1_dataOut : m0_dataOut;
                    // The slave gives we precedence, so re+we is a write.
                    rd_d     = sel_re & ~sel_we;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (s_ready || (wd_q >= WD_LAST)) begin
                    m0_done_d = ~gnt_q;
                    m1_done_d = gnt_q;
                    m0_err_d  = ~gnt_q & ~s_ready;
                    m1_err_d  = gnt_q & ~s_ready;
                    if (s_ready && rd_q) begin
                        if (gnt_q) m1_din_d = s_dataIn;
                        else       m0_din_d = s_dataIn;
                    end
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            rd_q      <= 1'b0;
            wd_q      <= '0;
            s_re_q    <= 1'b0;
            s_we_q    <= 1'b0;
            s_io_q    <= 1'b0;
            s_addr_q  <= '0;
            s_dout_q  <= '0;
            m0_din_q  <= '0;
            m1_din_q  <= '0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            rd_q      <= rd_d;
            wd_q      <= wd_d;
            s_re_q    <= s_re_d;
            s_we_q    <= s_we_d;
            s_io_q    <= s_io_d;
            s_addr_q  <= s_addr_d;
            s_dout_q  <= s_dout_d;
            m0_din_q  <= m0_din_d;
            m1_din_q  <= m1_din_d;
            m0_done_q <= m0_done_d;
            m1_done_q <= m1_done_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
        end
    end

    assign s_re      = s_re_q;
    assign s_we      = s_we_q;
    assign s_io      = s_io_q;
    assign s_addr    = s_addr_q;
    assign s_dataOut = s_dout_q;
    assign m0_dataIn = m0_din_q;
    assign m1_dataIn = m1_din_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign dbg_state = state_q;
endmodule
